data_mem_access: RTL
====================

# data_mem_access

Load/store sequencer between the single-cycle datapath's memory-stage signals and the byte-addressed, big-endian data memory (4 bytes written/read at A..A+3, combinational read). Accepts one word or byte load/store request at a time via a ready/req handshake and drives the memory port. Performs read-modify-write for byte stores so only the addressed byte changes. Returns the load result, a one-cycle done pulse and a fault flag for out-of-range (and optionally misaligned) accesses.

## Interface
- MEM_BYTES, 1024, data memory size in bytes; legal word/byte range check uses this.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe; accepted when req && ready.
- we  input  1  1 = store, 0 = load; sampled at accept.
- byte_en  input  1  1 = byte access, 0 = word access; sampled at accept.
- addr  input  32  byte address; sampled at accept.
- wdata  input  32  store data; byte store uses wdata[7:0]; sampled at accept.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse marking request completion.
- rdata  output  32  load result; held from done until next done.
- fault  output  1  valid with done; 1 = access rejected, memory untouched.
- mem_A  output  32  memory address.
- mem_WD  output  32  memory write data.
- mem_MemWrite  output  1  memory write enable.
- mem_RD  input  32  memory read data (combinational from mem_A).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: ready=1. On req: latch we, byte_en, addr, wdata; evaluate fault. fault → RESP. Else load or byte store → READ; word store → WRITE.
- READ: mem_A=latched addr; capture mem_RD into hold register at clock edge. Load → RESP; byte store → WRITE.
- WRITE: mem_A=latched addr, mem_MemWrite=1. mem_WD = wdata (word) or {wdata[7:0], hold[23:0]} (byte; address byte is MSByte of big-endian word). → RESP.
- RESP: done=1, fault as evaluated. rdata updated on entry: word load = hold; byte load = {24'b0, hold[31:24]}; store or fault = 32'b0. → IDLE.
- Range fault: addr + 3 > MEM_BYTES-1 (32-bit unsigned compare, addr ≥ MEM_BYTES-3 faults; no wrap). Applies to byte accesses too, since memory port always touches A..A+3.
- mem_MemWrite is 1 only in WRITE and forced 0 whenever reset=1 (combinational gating).
- mem_A holds latched addr in all states; mem_WD = 0 outside WRITE.
- req while not ready is ignored (not queued); requester must hold req until ready.

## Timing
- Reset values: state IDLE, ready=1 (after reset releases), done=0, fault=0, rdata=0, mem_MemWrite=0, mem_A=0, mem_WD=0, hold=0.
- Latency accept-edge to done: fault 1 cycle; word load 2; word store 2; byte load 2; byte store 3.
- Throughput: next request accepted the cycle after done (ready re-asserts in IDLE); no back-to-back overlap.
- Reset mid-operation (any state): abort at that edge, no write issued in the reset cycle, done not pulsed, return to IDLE.
- Byte store merge uses memory contents read in READ; no other writer exists, so no hazard.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: word access with addr[1:0] != 0 sets fault (1-cycle, no memory access); byte accesses never alignment-fault.
- Undefined: word accesses at any byte address permitted; only range fault applies.

## Test plan
- Word store addr=0x10 wdata=0xDEADBEEF, then word load 0x10 → WRITE one cycle with mem_MemWrite=1, done at +2; load done at +2 with rdata=0xDEADBEEF, fault=0.
- After above, byte store addr=0x11 wdata=0x000000A5 → done at +3; word load 0x10 returns 0xDEA5BEEF; byte load 0x11 returns 0x000000A5.
- Word load addr=0x3FD (MEM_BYTES=1024) → done at +1, fault=1, rdata=0, mem_MemWrite never high; addr=0x3FC succeeds.
- Word load addr=0x12: with DMEM_ALIGN_CHECK_EN → fault=1 at +1; without → fault=0, rdata = bytes 0x12..0x15.
- Byte store accepted, reset asserted during WRITE cycle → mem_MemWrite=0 that cycle, memory unchanged, done never pulses, ready=1 after reset drops.
- req held high while busy with differing addr → only first request serviced; second accepted on first IDLE cycle after done.

Source files
------------

// File: rtl/data_mem_access.sv
// Load/store sequencer between the datapath memory stage and a big-endian byte-addressed data memory.
// Optional macro DMEM_ALIGN_CHECK_EN adds a misalignment fault for word accesses.
module data_mem_access #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Highest address whose four-byte window A..A+3 still fits in memory.
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] hold_q, hold_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        req_fault;

  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    req_fault = (addr > LAST_WORD) || (!byte_en && (addr[1:0] != 2'b00));
`else
    req_fault = (addr > LAST_WORD);
`endif
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          byte_d  = byte_en;
          addr_d  = addr;
          wdata_d = wdata;
          if (req_fault) begin
            state_d = RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
            rdata_d = 32'h0000_0000;
          end else if (!we || byte_en) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Only the low three bytes are kept: the merge replaces the top (addressed) byte.
        hold_d = mem_RD[23:0];
        if (we_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
          done_d  = 1'b1;
          rdata_d = byte_q ? {24'h00_0000, mem_RD[31:24]} : mem_RD;
        end
      end
      WRITE: begin
        state_d = RESP;
        done_d  = 1'b1;
        rdata_d = 32'h0000_0000;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      hold_q  <= 24'h00_0000;
      rdata_q <= 32'h0000_0000;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    if (state_q == WRITE) begin
      mem_WD = byte_q ? {wdata_q[7:0], hold_q} : wdata_q;
    end else begin
      mem_WD = 32'h0000_0000;
    end
  end

  // Reset gates the write strobe directly so an aborted WRITE never reaches memory.
  assign mem_MemWrite = (state_q == WRITE) && !reset;
  assign mem_A        = addr_q;
  assign ready        = (state_q == IDLE);
  assign done         = done_q;
  assign fault        = fault_q;
  assign rdata        = rdata_q;

endmodule
